regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file. Successor to the single-config 2R1W core regfile.
- Generalised in data width, register count and read-port count.
- Adds optional write-to-read forwarding and a sequential clear engine (one register per cycle, busy/done handshake).
- Sits between decode (read addresses) and writeback (write port) of the RV32I pipeline.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..64, need not be a power of two)
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero; 0 = register 0 is ordinary storage
(derived, not overridable) AW = clog2(NREGS), register address width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
write_en  input  1  write strobe
write_reg  input  AW  write address
write_data  input  XLEN  write data
rs  input  NREAD*AW  read addresses, port k at bits [k*AW +: AW]
rdata  output  NREAD*XLEN  registered read data, port k at bits [k*XLEN +: XLEN]
clear_req  input  1  request a full sequential clear
busy  output  1  clear engine active
clear_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset (reset==0, async): all NREGS registers = 0, rdata = 0, busy = 0, clear_done = 0, clear counter = 0, FSM = IDLE. Outputs stay at these values until the first rising edge after reset deasserts.
- Write, rising edge:
  - In IDLE, with write_en=1, write_reg < NREGS, and not (ZERO_REG && write_reg==0): reg[write_reg] <= write_data.
  - All other writes are dropped with no side effect.
- Read latency is one cycle. At each edge, rdata[k] <= reg[rs[k]] (pre-write value), evaluated independently per port.
- Read address checks: rs[k] >= NREGS returns 0. With ZERO_REG, rs[k]==0 always returns 0.
- Duplicate read addresses on several ports are legal; every such port returns identical data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req=1. Counter cnt <= 0 and busy <= 1 on that edge.
  - A write presented in the same cycle as clear_req is still performed; the sweep later zeroes it.
  - In CLEAR, each edge: reg[cnt] <= 0, cnt <= cnt+1.
  - When cnt==NREGS-1, that register is zeroed, the FSM returns to IDLE, busy <= 0, and clear_done <= 1 for exactly one cycle.
  - A sweep takes exactly NREGS cycles with busy high.
- During CLEAR:
  - write_en is ignored.
  - clear_req is ignored (no restart, no queueing).
  - Reads continue normally: registers not yet swept return old data; swept ones return 0.
- clear_req asserted in the cycle clear_done is high starts a new sweep (FSM already IDLE).
- Reset asserted mid-sweep aborts it immediately: all state returns to reset values and no clear_done is issued.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN
- Defined: a read port whose rs[k] equals an accepted write address in the same cycle gets rdata[k] <= write_data instead of the stale value.
  - "Accepted" means the same acceptance rules as Write (IDLE, in range, not a hardwired-zero reg0).
  - Dropped writes are never forwarded.
  - Forwarding applies to each port independently.
- Undefined: no forwarding; rdata[k] shows the pre-write value, and the new value appears one cycle later.

Test Plan:
- Reset then read: hold reset=0, release. With rs={3,0}, rdata reads 0 on both ports next cycle. busy=0, clear_done=0.
- Write/read with ZERO_REG=1:
  - Write reg5=0xDEADBEEF, then rs[0]=5 gives 0xDEADBEEF after one cycle.
  - Write reg0=0x1234 is dropped; rs[1]=0 reads 0.
- Same-cycle write/read to reg7: write_data=0xA5A5A5A5 while rs[0]=7 (old value 0x11).
  - With REGFILE_MP_BYPASS_EN: rdata[0]=0xA5A5A5A5.
  - Without: 0x11, then 0xA5A5A5A5 on the following cycle.
- Clear sweep, NREGS=32:
  - Fill all regs with their index+1, then pulse clear_req. busy is high for exactly 32 cycles and clear_done pulses once on the 32nd edge.
  - Mid-sweep (cycle 10), reg20 still reads 21 and reg3 reads 0.
  - A write to reg9 during the sweep is dropped; all regs read 0 afterwards.
- Reset mid-sweep: assert reset=0 at sweep cycle 5. busy, rdata and all regs are 0 immediately, and no clear_done pulse follows.
- Config NREGS=24, NREAD=4, ZERO_REG=0:
  - reg0 is writable (write 0x55 reads 0x55).
  - A write to address 30 is dropped; a read of address 30 returns 0.
  - 4 ports reading {1,1,2,23} return matching data simultaneously.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a sequential clear engine; optional write-to-read forwarding under REGFILE_MP_BYPASS_EN.
// Latency: 1 cycle from read address to rdata; a clear sweep takes NREGS cycles.
// Backpressure: none; while busy, writes and clear requests are ignored and reads continue.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [AW-1:0]         write_reg,
    input  logic [XLEN-1:0]       write_data,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] rdata,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clear_done
);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    logic [XLEN-1:0] regs [NREGS];
    logic [0:0]      state;
    logic [AW-1:0]   cnt;
    logic            wr_acc;
    logic            clearing;

    assign clearing = (state == S_CLEAR);
    assign busy     = clearing;
    // Writes to out-of-range addresses or a hardwired register 0 are dropped outright.
    assign wr_acc   = !clearing && write_en && ({1'b0, write_reg} < NREGS_W) &&
                      !((ZERO_REG != 0) && (write_reg == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state <= S_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (cnt == LAST) begin
                        state      <= S_IDLE;
                        cnt        <= '0;
                        clear_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (clearing && (cnt == AW'(i)))
                    regs[i] <= '0;
                else if (wr_acc && (write_reg == AW'(i)))
                    regs[i] <= write_data;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] nxt;
        logic [XLEN-1:0] q;

        assign addr = rs[k*AW +: AW];

        always_comb begin
            nxt = '0;
            if (({1'b0, addr} < NREGS_W) && !((ZERO_REG != 0) && (addr == '0)))
                nxt = regs[addr];
`ifdef REGFILE_MP_BYPASS_EN
            // Only accepted writes forward, so a dropped write never leaks to a reader.
            if (wr_acc && (addr == write_reg))
                nxt = write_data;
`endif
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) q <= '0;
            else        q <= nxt;
        end

        assign rdata[k*XLEN +: XLEN] = q;
    end

endmodule
